// File: rtl/fp_mul_arb_pkg.sv
// fp_mul_arb_pkg: default widths, stage bundle types and helpers
// shared by the fp_mul_rr_arb arbiter slice.
package fp_mul_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int I_DEF    = 2;
    localparam int F_DEF    = 14;
    localparam int W_DEF    = I_DEF + F_DEF;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEF = idw(NREQ_DEF);

    typedef struct packed {
        logic [W_DEF-1:0]   a;
        logic               s1;
        logic [W_DEF-1:0]   b;
        logic               s2;
        logic [IDW_DEF-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [W_DEF-1:0]   c;
        logic               sign;
        logic               ovf;
        logic               unf;
        logic [IDW_DEF-1:0] id;
    } s2_t;

    function automatic logic [63:0] sat_max(input int w, input logic sgn);
        return sgn ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w, input logic sgn);
        return sgn ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/fp_mul.sv
// fp_mul: combinational Qi.f multiplier with per-operand sign flags.
// Product is floor-truncated to Qi3.f3; sign = s1|s2.
module fp_mul #(
    parameter int i1 = 2,
    parameter int f1 = 14,
    parameter int i2 = 2,
    parameter int f2 = 14,
    parameter int i3 = 2,
    parameter int f3 = 14
) (
    input  logic [i1+f1-1:0] a_i,
    input  logic             s1_i,
    input  logic [i2+f2-1:0] b_i,
    input  logic             s2_i,
    output logic [i3+f3-1:0] c_o,
    output logic             sign_o,
    output logic             ovf_o,
    output logic             unf_o
);
    localparam int W1 = i1 + f1;
    localparam int W2 = i2 + f2;
    localparam int W3 = i3 + f3;
    localparam int SH = f1 + f2 - f3;
    localparam int LS = (SH < 0) ? -SH : 0;
    localparam int RS = (SH > 0) ? SH : 0;
    localparam int XW = W1 + W2 + 2;
    localparam int PW = XW + LS;

    localparam logic signed [PW-1:0] MAXS =
        $signed({{(PW-W3+1){1'b0}}, {(W3-1){1'b1}}});
    localparam logic signed [PW-1:0] MINS =
        $signed({{(PW-W3+1){1'b1}}, {(W3-1){1'b0}}});
    localparam logic signed [PW-1:0] MAXU =
        $signed({{(PW-W3){1'b0}}, {W3{1'b1}}});

    logic signed [XW-1:0] xa;
    logic signed [XW-1:0] xb;
    logic signed [XW-1:0] prod;
    logic signed [PW-1:0] pe;
    logic signed [PW-1:0] q;

    // widen so the product is exact before re-scaling
    assign xa = $signed({{(W2+1){s1_i & a_i[W1-1]}}, a_i});
    assign xb = $signed({{(W1+1){s2_i & b_i[W2-1]}}, b_i});
    assign prod = xa * xb;
    assign pe = PW'(prod);
    assign q = (pe <<< LS) >>> RS;

    assign sign_o = s1_i | s2_i;
    assign c_o = q[W3-1:0];
    assign ovf_o = sign_o ? (q > MAXS) : (q > MAXU);
    assign unf_o = sign_o ? (q < MINS) : q[PW-1];

endmodule

// File: rtl/fp_mul_rr_grant.sv
// fp_mul_rr_grant: combinational round-robin pick, scanning
// upward from ptr_i with wrap at NREQ-1.
module fp_mul_rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_o
);
    int k;

    always_comb begin
        grant_o = '0;
        any_o = 1'b0;
        k = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!any_o && req_valid_i[k]) begin
                grant_o = IDW'(k);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_rr_arb.sv
// fp_mul_rr_arb: round-robin share of one fp_mul, two-stage pipeline.
// Define FP_MUL_ARB_SAT_EN to saturate rsp_c on overflow/underflow.
import fp_mul_arb_pkg::*;

module fp_mul_rr_arb #(
    parameter int NREQ = NREQ_DEF,
    parameter int i1   = I_DEF,
    parameter int f1   = F_DEF,
    parameter int i2   = I_DEF,
    parameter int f2   = F_DEF,
    parameter int i3   = I_DEF,
    parameter int f3   = F_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*(i1+f1)-1:0]  req_a,
    input  logic [NREQ-1:0]          req_s1,
    input  logic [NREQ*(i2+f2)-1:0]  req_b,
    input  logic [NREQ-1:0]          req_s2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [idw(NREQ)-1:0]     rsp_id,
    output logic [i3+f3-1:0]         rsp_c,
    output logic                     rsp_sign,
    output logic                     rsp_overflow,
    output logic                     rsp_underflow
);
    localparam int IDW = idw(NREQ);
    localparam int W1  = i1 + f1;
    localparam int W2  = i2 + f2;
    localparam int W3  = i3 + f3;

    typedef struct packed {
        logic [W1-1:0]  a;
        logic           s1;
        logic [W2-1:0]  b;
        logic           s2;
        logic [IDW-1:0] id;
    } st1_t;

    typedef struct packed {
        logic [W3-1:0]  c;
        logic           sign;
        logic           ovf;
        logic           unf;
        logic [IDW-1:0] id;
    } st2_t;

    st1_t           s1_q, s1_d;
    st2_t           s2_q, s2_d;
    logic           v1_q, v1_d;
    logic           v2_q, v2_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [IDW-1:0] grant;
    logic           any;
    logic           ld1, ld2, accept;
    logic [W3-1:0]  mc, cap_c;
    logic           msign, movf, munf;

    fp_mul_rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .any_o       (any)
    );

    fp_mul #(
        .i1(i1), .f1(f1), .i2(i2), .f2(f2), .i3(i3), .f3(f3)
    ) u_mul (
        .a_i    (s1_q.a),
        .s1_i   (s1_q.s1),
        .b_i    (s1_q.b),
        .s2_i   (s1_q.s2),
        .c_o    (mc),
        .sign_o (msign),
        .ovf_o  (movf),
        .unf_o  (munf)
    );

    assign ld2 = v1_q & (~v2_q | rsp_ready);
    assign ld1 = ~v1_q | ld2;
    // ready stays low while reset is held, even though the pipe looks empty
    assign accept = rst_n & ld1 & any;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

`ifdef FP_MUL_ARB_SAT_EN
    always_comb begin
        cap_c = mc;
        if (movf) cap_c = W3'(sat_max(W3, msign));
        else if (munf) cap_c = W3'(sat_min(W3, msign));
    end
`else
    assign cap_c = mc;
`endif

    always_comb begin
        s1_d = s1_q;
        v1_d = v1_q;
        s2_d = s2_q;
        v2_d = v2_q;
        ptr_d = ptr_q;
        if (ld2) begin
            s2_d.c = cap_c;
            s2_d.sign = msign;
            s2_d.ovf = movf;
            s2_d.unf = munf;
            s2_d.id = s1_q.id;
            v2_d = 1'b1;
            v1_d = 1'b0;
        end else if (rsp_ready) begin
            v2_d = 1'b0;
        end
        if (accept) begin
            s1_d.a = req_a[int'(grant)*W1 +: W1];
            s1_d.s1 = req_s1[grant];
            s1_d.b = req_b[int'(grant)*W2 +: W2];
            s1_d.s2 = req_s2[grant];
            s1_d.id = grant;
            v1_d = 1'b1;
            if (int'(grant) == NREQ - 1) ptr_d = '0;
            else ptr_d = grant + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            v1_q <= 1'b0;
            s2_q <= '0;
            v2_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            s1_q <= s1_d;
            v1_q <= v1_d;
            s2_q <= s2_d;
            v2_q <= v2_d;
            ptr_q <= ptr_d;
        end
    end

    assign rsp_valid = v2_q;
    assign rsp_id = s2_q.id;
    assign rsp_c = s2_q.c;
    assign rsp_sign = s2_q.sign;
    assign rsp_overflow = s2_q.ovf;
    assign rsp_underflow = s2_q.unf;

endmodule

// File: tb/tb_fp_mul_rr_arb.sv
// tb_fp_mul_rr_arb: random and directed stimulus for fp_mul_rr_arb,
// checked against a queue-based arbiter and arithmetic reference.
module tb_fp_mul_rr_arb;
    import fp_mul_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N-1:0]   req_s1 = '0;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_s2 = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_c;
    logic           rsp_sign, rsp_overflow, rsp_underflow;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[g*W +: W] = op_a[g];
        assign req_b[g*W +: W] = op_b[g];
    end

    fp_mul_rr_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_s1        (req_s1),
        .req_b         (req_b),
        .req_s2        (req_s2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_c         (rsp_c),
        .rsp_sign      (rsp_sign),
        .rsp_overflow  (rsp_overflow),
        .rsp_underflow (rsp_underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mptr = 0;
    int rsp_count = 0;
    bit mon_en = 1'b0;
    logic [N-1:0] acc_mask = '0;
    logic [N-1:0] keep = '0;
    s2_t sb [$];
    int acc_edge [$];
    int acc_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic s2_t model(input logic [W-1:0] a, input logic s1,
                                  input logic [W-1:0] b, input logic s2,
                                  input int id);
        longint va, vb, q;
        s2_t e;
        va = s1 ? longint'($signed(a)) : longint'(a);
        vb = s2 ? longint'($signed(b)) : longint'(b);
        q = (va * vb) >>> 14;
        e.sign = s1 | s2;
        if (e.sign) begin
            e.ovf = (q > 32767);
            e.unf = (q < -32768);
        end else begin
            e.ovf = (q > 65535);
            e.unf = (q < 0);
        end
        e.c = q[15:0];
`ifdef FP_MUL_ARB_SAT_EN
        if (e.ovf) e.c = e.sign ? 16'h7FFF : 16'hFFFF;
        else if (e.unf) e.c = e.sign ? 16'h8000 : 16'h0000;
`endif
        e.id = IDW'(id);
        return e;
    endfunction

    logic [N-1:0] er;
    bit ev;
    int gk;

    // handshakes are settled half a cycle before the edge that takes them
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            er = '0;
            gk = 0;
            if (|req_valid && (sb.size() < 2 || rsp_ready)) begin
                for (int i = N - 1; i >= 0; i--)
                    if (req_valid[(mptr + i) % N]) gk = (mptr + i) % N;
                er[gk] = 1'b1;
            end
            tests++;
            if (req_ready !== er) begin
                fails++;
                $display("FAIL grant: req_ready=%b expected %b t=%0t",
                         req_ready, er, $time);
            end
            ev = (sb.size() > 0) && (cyc >= acc_edge[0] + 1);
            tests++;
            if (rsp_valid !== ev) begin
                fails++;
                $display("FAIL rsp_valid: got %b expected %b t=%0t",
                         rsp_valid, ev, $time);
            end
            if (rsp_valid && sb.size() > 0) begin
                tests++;
                if ({rsp_c, rsp_sign, rsp_overflow, rsp_underflow, rsp_id}
                    !== sb[0]) begin
                    fails++;
                    $display("FAIL rsp_data: got c=%h s=%b o=%b u=%b id=%0d expected c=%h s=%b o=%b u=%b id=%0d",
                             rsp_c, rsp_sign, rsp_overflow, rsp_underflow,
                             rsp_id, sb[0].c, sb[0].sign, sb[0].ovf,
                             sb[0].unf, sb[0].id);
                end
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                sb.delete(0);
                acc_edge.delete(0);
                rsp_count++;
            end
            for (int j = 0; j < N; j++) begin
                if (req_valid[j] && req_ready[j]) begin
                    sb.push_back(model(op_a[j], req_s1[j], op_b[j],
                                       req_s2[j], j));
                    acc_edge.push_back(cyc + 1);
                    acc_log.push_back(j);
                    mptr = (j + 1) % N;
                    acc_mask[j] = 1'b1;
                end
            end
        end
    end

    task automatic new_op(input int k);
        op_a[k] = W'($urandom);
        op_b[k] = W'($urandom);
        req_s1[k] = 1'($urandom);
        req_s2[k] = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc_mask[k]) begin
                if (keep[k]) new_op(k);
                else req_valid[k] = 1'b0;
            end
        end
        acc_mask = '0;
    endtask

    task automatic drain();
        keep = '0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || rsp_valid); i++)
            step();
        tests++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain: pending=%0d rsp_valid=%b expected 0/0",
                     sb.size(), rsp_valid);
        end
    endtask

    task automatic issue(input int k, input logic [W-1:0] a, input logic s1,
                         input logic [W-1:0] b, input logic s2,
                         output bit got, output bit early);
        op_a[k] = a;
        op_b[k] = b;
        req_s1[k] = s1;
        req_s2[k] = s2;
        keep = '0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[k] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                got = 1'b1;
                break;
            end
        end
        step();
        early = rsp_valid;
        step();
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) new_op(k);
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: req_ready=%b rsp_valid=%b expected 0",
                     req_ready, rsp_valid);
        end
        tests++;
        if ({rsp_c, rsp_id, rsp_sign, rsp_overflow, rsp_underflow} !== '0)
        begin
            fails++;
            $display("FAIL reset_data: c=%h id=%0d flags=%b%b%b expected 0",
                     rsp_c, rsp_id, rsp_sign, rsp_overflow, rsp_underflow);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mptr = 0;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit got, early;
        issue(0, 16'h6000, 1'b0, 16'h5000, 1'b0, got, early);
        tests++;
        if (!got || early !== 1'b0) begin
            fails++;
            $display("FAIL single_lat: accepted=%b early_valid=%b expected 1/0",
                     got, early);
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== 16'h7800 ||
            {rsp_sign, rsp_overflow, rsp_underflow} !== 3'b000) begin
            fails++;
            $display("FAIL single: v=%b id=%0d c=%h flags=%b%b%b expected 1 0 7800 000",
                     rsp_valid, rsp_id, rsp_c, rsp_sign, rsp_overflow,
                     rsp_underflow);
        end
        drain();
    endtask

    task automatic test_signed();
        bit got, early;
        issue(2, 16'hC000, 1'b1, 16'h2000, 1'b1, got, early);
        tests++;
        if (!got || rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
            rsp_sign !== 1'b1 || rsp_c !== 16'hE000 ||
            {rsp_overflow, rsp_underflow} !== 2'b00) begin
            fails++;
            $display("FAIL signed: acc=%b v=%b id=%0d s=%b c=%h of=%b%b expected 1 1 2 1 e000 00",
                     got, rsp_valid, rsp_id, rsp_sign, rsp_c, rsp_overflow,
                     rsp_underflow);
        end
        drain();
    endtask

    task automatic test_overflow();
        bit got, early;
        logic [W-1:0] exp_c;
`ifdef FP_MUL_ARB_SAT_EN
        exp_c = 16'hFFFF;
`else
        exp_c = 16'h8000;
`endif
        issue(1, 16'hC000, 1'b0, 16'h8000, 1'b0, got, early);
        tests++;
        if (!got || rsp_valid !== 1'b1 || rsp_id !== 2'd1 ||
            rsp_overflow !== 1'b1 || rsp_underflow !== 1'b0 ||
            rsp_sign !== 1'b0 || rsp_c !== exp_c) begin
            fails++;
            $display("FAIL overflow: acc=%b v=%b id=%0d c=%h s=%b of=%b uf=%b expected c=%h of=1",
                     got, rsp_valid, rsp_id, rsp_c, rsp_sign, rsp_overflow,
                     rsp_underflow, exp_c);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int start;
        bit order_ok;
        keep = '1;
        for (int k = 0; k < N; k++) new_op(k);
        req_valid = '1;
        rsp_ready = 1'b1;
        acc_log.delete();
        start = mptr;
        repeat (12) step();
        order_ok = 1'b1;
        foreach (acc_log[i])
            if (acc_log[i] != (start + i) % N) order_ok = 1'b0;
        tests++;
        if (acc_log.size() != 12 || !order_ok) begin
            fails++;
            $display("FAIL round_robin: accepts=%0d in_order=%b expected 12/1",
                     acc_log.size(), order_ok);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int rc0;
        logic [W+IDW+2:0] snap;
        keep = '1;
        for (int k = 0; k < N; k++) new_op(k);
        req_valid = '1;
        rsp_ready = 1'b0;
        acc_log.delete();
        rc0 = rsp_count;
        repeat (5) step();
        tests++;
        if (acc_log.size() != 2 || req_ready !== '0) begin
            fails++;
            $display("FAIL bp_fill: accepts=%0d req_ready=%b expected 2/0000",
                     acc_log.size(), req_ready);
        end
        snap = {rsp_c, rsp_sign, rsp_overflow, rsp_underflow, rsp_id};
        step();
        tests++;
        if ({rsp_c, rsp_sign, rsp_overflow, rsp_underflow, rsp_id} !== snap ||
            rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: got %h v=%b expected %h v=1",
                     {rsp_c, rsp_sign, rsp_overflow, rsp_underflow, rsp_id},
                     rsp_valid, snap);
        end
        keep = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && req_valid != '0; i++) step();
        drain();
        tests++;
        if (acc_log.size() != 6 || rsp_count - rc0 != 6) begin
            fails++;
            $display("FAIL bp_release: accepts=%0d responses=%0d expected 6/6",
                     acc_log.size(), rsp_count - rc0);
        end
    endtask

    task automatic test_random();
        keep = '1;
        for (int c = 0; c < 400; c++) begin
            step();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    new_op(k);
                    req_valid[k] = 1'b1;
                end else if (req_valid[k] && $urandom_range(0, 7) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        keep = '1;
        for (int k = 0; k < N; k++) new_op(k);
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        tests++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 ||
            {rsp_c, rsp_id, rsp_sign, rsp_overflow, rsp_underflow} !== '0)
        begin
            fails++;
            $display("FAIL reset_mid: rdy=%b v=%b c=%h id=%0d flags=%b%b%b expected all 0",
                     req_ready, rsp_valid, rsp_c, rsp_id, rsp_sign,
                     rsp_overflow, rsp_underflow);
        end
        sb.delete();
        acc_edge.delete();
        acc_mask = '0;
        mptr = 0;
        keep = '0;
        rsp_ready = 1'b1;
        req_valid = 4'b1100;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL reset_ptr: req_ready=%b expected 0100", req_ready);
        end
        mon_en = 1'b1;
        step();
        drain();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        test_reset();
        test_single();
        test_signed();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
